// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter:
// FSM state encoding, byte-enable constants, default widths and small helpers.
package mem_port_arbiter_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    localparam logic [3:0] WE_NONE = 4'b0000;
    localparam logic [3:0] WE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    // A data access is a store when any byte lane is enabled.
    function automatic logic is_write(input logic [3:0] we);
        return (we != WE_NONE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the memory port arbiter: fetch port, data port, memory
// port, pipeline stalls and performance counters.
// slave  : the arbiter's view (serves the CPU ports, drives the memory command).
// master : the surrounding system's view (CPU requesters plus memory model).
interface mem_port_arbiter_if #(
    parameter int AW = mem_port_arbiter_pkg::DEF_AW,
    parameter int DW = mem_port_arbiter_pkg::DEF_DW
);
    // instruction-fetch port
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    // data (MEM-stage) port
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic [3:0]    d_we;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    // pipeline freeze controls
    logic          if_stall;
    logic          mem_stall;
    // memory port
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_we;
    logic [DW-1:0] mem_wdata;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    // stall statistics
    logic [31:0]   perf_i_wait;
    logic [31:0]   perf_d_wait;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_rvalid, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               if_stall, mem_stall, mem_req, mem_addr, mem_we, mem_wdata,
               perf_i_wait, perf_d_wait
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_rvalid, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               if_stall, mem_stall, mem_req, mem_addr, mem_we, mem_wdata,
               perf_i_wait, perf_d_wait
    );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Fetch starvation tracker: counts data grants issued while a fetch waits,
// saturating at MAX_STARVE, and flags when the fetch must be forced through.
module mem_arb_starve_ctr #(
    parameter int MAX_STARVE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic d_grant,
    input  logic i_grant,
    input  logic i_req,
    output logic force_fetch
);
    localparam logic [3:0] MAX_C = 4'(MAX_STARVE);

    logic [3:0] starve_cnt_r;

    // Any fetch grant clears the count; data grants over a waiting fetch bump it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_r <= 4'd0;
        end else if (i_grant) begin
            starve_cnt_r <= 4'd0;
        end else if (d_grant && i_req && (starve_cnt_r != MAX_C)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign force_fetch = (starve_cnt_r == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// data port. Data has priority; the starvation counter forces a waiting fetch
// through after MAX_STARVE consecutive data grants. One read is outstanding at
// a time; stores complete in their grant cycle.
// Optional build macro MEM_ARB_PERF_EN adds 32-bit stall-cycle counters;
// without it perf_i_wait/perf_d_wait are constant zero.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int MAX_STARVE = 3
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    arb_state_e    state_r;
    logic          active_s;
    logic          idle_s;
    logic          force_fetch_s;
    logic          grant_d_s;
    logic          grant_i_s;
    logic          d_write_s;
    logic          i_rvalid_s;
    logic          d_rvalid_s;
    logic          if_stall_s;
    logic          mem_stall_s;
    logic [AW-1:0] mem_addr_s;
    logic [DW-1:0] mem_wdata_s;
    logic [3:0]    mem_we_s;

    // Outputs are forced low while reset is held, whatever the requesters do.
    assign active_s  = reset;
    assign idle_s    = active_s && (state_r == IDLE);
    assign d_write_s = is_write(bus.d_we);

    mem_arb_starve_ctr #(
        .MAX_STARVE (MAX_STARVE)
    ) u_starve (
        .clk         (clk),
        .reset       (reset),
        .d_grant     (grant_d_s),
        .i_grant     (grant_i_s),
        .i_req       (bus.i_req),
        .force_fetch (force_fetch_s)
    );

    // Same-cycle grant decision in IDLE: data first unless fetch is being forced.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (idle_s) begin
            if (bus.d_req && !(bus.i_req && force_fetch_s)) begin
                grant_d_s = 1'b1;
            end else if (bus.i_req) begin
                grant_i_s = 1'b1;
            end else begin
                grant_d_s = 1'b0;
                grant_i_s = 1'b0;
            end
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Memory command mux: fetches always read, so they carry no enables or data.
    always_comb begin
        mem_addr_s  = '0;
        mem_we_s    = WE_NONE;
        mem_wdata_s = '0;
        if (grant_d_s) begin
            mem_addr_s  = bus.d_addr;
            mem_we_s    = bus.d_we;
            mem_wdata_s = bus.d_wdata;
        end else if (grant_i_s) begin
            mem_addr_s  = bus.i_addr;
            mem_we_s    = WE_NONE;
            mem_wdata_s = '0;
        end else begin
            mem_addr_s  = '0;
            mem_we_s    = WE_NONE;
            mem_wdata_s = '0;
        end
    end

    // Response routing: only the owner of the outstanding read sees mem_rvalid.
    assign i_rvalid_s = active_s && (state_r == BUSY_I) && bus.mem_rvalid;
    assign d_rvalid_s = active_s && (state_r == BUSY_D) && bus.mem_rvalid;

    // A store releases the MEM stage in its grant cycle; a load on its response.
    assign if_stall_s  = active_s && bus.i_req && !i_rvalid_s;
    assign mem_stall_s = active_s && bus.d_req && !(d_rvalid_s || (grant_d_s && d_write_s));

    assign bus.mem_req   = grant_d_s || grant_i_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.i_gnt     = grant_i_s;
    assign bus.d_gnt     = grant_d_s;
    assign bus.i_rvalid  = i_rvalid_s;
    assign bus.d_rvalid  = d_rvalid_s;
    assign bus.i_rdata   = i_rvalid_s ? bus.mem_rdata : '0;
    assign bus.d_rdata   = d_rvalid_s ? bus.mem_rdata : '0;
    assign bus.if_stall  = if_stall_s;
    assign bus.mem_stall = mem_stall_s;

    // Transaction FSM: a read grant occupies the port until its response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_d_s && !d_write_s) begin
                        state_r <= BUSY_D;
                    end else if (grant_i_s) begin
                        state_r <= BUSY_I;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_I: begin
                    if (bus.mem_rvalid) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= BUSY_I;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_rvalid) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= BUSY_D;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_r;
    logic [31:0] perf_d_r;

    // Free-running stall-cycle counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_i_r <= 32'd0;
            perf_d_r <= 32'd0;
        end else begin
            if (if_stall_s) begin
                perf_i_r <= perf_i_r + 32'd1;
            end else begin
                perf_i_r <= perf_i_r;
            end
            if (mem_stall_s) begin
                perf_d_r <= perf_d_r + 32'd1;
            end else begin
                perf_d_r <= perf_d_r;
            end
        end
    end

    assign bus.perf_i_wait = perf_i_r;
    assign bus.perf_d_wait = perf_d_r;
`else
    assign bus.perf_i_wait = 32'd0;
    assign bus.perf_d_wait = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STARVE(MAXS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // memory contents and model state
    logic [31:0] mem [0:255];
    int          owner;      // 0: port free, 1: fetch read pending, 2: data read pending
    int          starve;     // data grants given while a fetch waited
    bit          pend;       // memory still has to answer a read
    int          rem;        // cycles until that answer
    logic [31:0] pend_data;
    int          lat_sel;    // 0: random latency 1..4, else fixed
    bit          spur_en;
    bit          force_rv;
    bit          cur_rv;
    logic [31:0] perf_i;
    logic [31:0] perf_d;

    // expected outputs for the current cycle
    logic        e_i_gnt, e_d_gnt, e_i_rv, e_d_rv, e_if_stall, e_mem_stall, e_mem_req;
    logic [31:0] e_mem_addr, e_mem_wdata, e_i_rdata, e_d_rdata;
    logic [3:0]  e_mem_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive the memory response, let logic settle, then compare every output.
    task automatic eval();
        logic        rv;
        logic [31:0] rd;
        rv = 1'b0;
        rd = $urandom;
        if (reset && pend) begin
            rem--;
            if (rem == 0) begin
                rv   = 1'b1;
                rd   = pend_data;
                pend = 1'b0;
            end
        end
        if (force_rv) rv = 1'b1;
        if (spur_en && owner == 0 && !pend && $urandom_range(0, 5) == 0) rv = 1'b1;
        bus.mem_rvalid = rv;
        bus.mem_rdata  = rd;
        cur_rv = rv;
        #2;
        if (!reset) begin
            e_d_gnt = 0; e_i_gnt = 0; e_i_rv = 0; e_d_rv = 0;
            e_if_stall = 0; e_mem_stall = 0; e_mem_req = 0;
            e_mem_addr = 0; e_mem_we = 0; e_mem_wdata = 0; e_i_rdata = 0; e_d_rdata = 0;
        end else begin
            e_d_gnt     = (owner == 0) && bus.d_req && !(bus.i_req && starve == MAXS);
            e_i_gnt     = (owner == 0) && !e_d_gnt && bus.i_req;
            e_mem_req   = e_d_gnt || e_i_gnt;
            e_mem_addr  = e_d_gnt ? bus.d_addr : (e_i_gnt ? bus.i_addr : 32'd0);
            e_mem_we    = e_d_gnt ? bus.d_we : 4'd0;
            e_mem_wdata = e_d_gnt ? bus.d_wdata : 32'd0;
            e_i_rv      = (owner == 1) && rv;
            e_d_rv      = (owner == 2) && rv;
            e_i_rdata   = e_i_rv ? rd : 32'd0;
            e_d_rdata   = e_d_rv ? rd : 32'd0;
            e_if_stall  = bus.i_req && !e_i_rv;
            e_mem_stall = bus.d_req && !(e_d_rv || (e_d_gnt && bus.d_we != 4'd0));
        end
        chk("i_gnt", bus.i_gnt, e_i_gnt);
        chk("d_gnt", bus.d_gnt, e_d_gnt);
        chk("i_rvalid", bus.i_rvalid, e_i_rv);
        chk("d_rvalid", bus.d_rvalid, e_d_rv);
        chk("i_rdata", bus.i_rdata, e_i_rdata);
        chk("d_rdata", bus.d_rdata, e_d_rdata);
        chk("if_stall", bus.if_stall, e_if_stall);
        chk("mem_stall", bus.mem_stall, e_mem_stall);
        chk("mem_req", bus.mem_req, e_mem_req);
        chk("mem_addr", bus.mem_addr, e_mem_addr);
        chk("mem_we", bus.mem_we, e_mem_we);
        chk("mem_wdata", bus.mem_wdata, e_mem_wdata);
`ifdef MEM_ARB_PERF_EN
        chk("perf_i_wait", bus.perf_i_wait, perf_i);
        chk("perf_d_wait", bus.perf_d_wait, perf_d);
`else
        chk("perf_i_wait", bus.perf_i_wait, 32'd0);
        chk("perf_d_wait", bus.perf_d_wait, 32'd0);
`endif
    endtask

    task automatic issue_read(input logic [31:0] addr);
        pend      = 1'b1;
        rem       = (lat_sel != 0) ? lat_sel : $urandom_range(1, 4);
        pend_data = mem[addr[9:2]];
    endtask

    // Advance the model by one cycle and move to just after the next edge.
    task automatic adv();
        if (!reset) begin
            owner = 0; starve = 0; pend = 1'b0; perf_i = 32'd0; perf_d = 32'd0;
        end else begin
            if (owner != 0 && cur_rv) owner = 0;
            if (e_d_gnt) begin
                if (bus.d_we != 4'd0) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.d_we[b]) mem[bus.d_addr[9:2]][8*b +: 8] = bus.d_wdata[8*b +: 8];
                end else begin
                    owner = 2;
                    issue_read(bus.d_addr);
                end
                if (bus.i_req) starve = (starve < MAXS) ? starve + 1 : MAXS;
            end
            if (e_i_gnt) begin
                owner  = 1;
                starve = 0;
                issue_read(bus.i_addr);
            end
            perf_i = perf_i + {31'd0, e_if_stall};
            perf_d = perf_d + {31'd0, e_mem_stall};
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_i, second_i, dg, r;
        bit i_act, d_act;
        for (int k = 0; k < 256; k++) mem[k] = $urandom;
        owner = 0; starve = 0; pend = 0; rem = 0; pend_data = 0; lat_sel = 0;
        spur_en = 0; force_rv = 1; cur_rv = 0; perf_i = 0; perf_d = 0;
        bus.i_req = 1; bus.i_addr = 32'h10; bus.d_req = 1; bus.d_addr = 32'h20;
        bus.d_we = 4'hF; bus.d_wdata = 32'h1234_5678;
        bus.mem_rvalid = 0; bus.mem_rdata = 0;
        @(posedge clk); #1;

        // reset with every input active: all outputs stay low
        repeat (3) begin
            eval();
            chk("rst_mem_req", bus.mem_req, 32'd0);
            chk("rst_d_gnt", bus.d_gnt, 32'd0);
            chk("rst_if_stall", bus.if_stall, 32'd0);
            adv();
        end
        reset = 1; force_rv = 0; bus.i_req = 0; bus.d_req = 0; bus.d_we = 4'h0;
        eval(); adv();

        // lone fetch at 0x10, latency 2
        mem[4] = 32'hCAFE_0010; lat_sel = 2; bus.i_req = 1; bus.i_addr = 32'h10;
        eval();
        chk("t1_i_gnt", bus.i_gnt, 32'd1);
        chk("t1_mem_req", bus.mem_req, 32'd1);
        chk("t1_mem_addr", bus.mem_addr, 32'h10);
        chk("t1_if_stall_c0", bus.if_stall, 32'd1);
        adv();
        eval();
        chk("t1_if_stall_c1", bus.if_stall, 32'd1);
        chk("t1_i_rvalid_c1", bus.i_rvalid, 32'd0);
        adv();
        eval();
        chk("t1_i_rvalid_c2", bus.i_rvalid, 32'd1);
        chk("t1_i_rdata", bus.i_rdata, 32'hCAFE_0010);
        chk("t1_if_stall_c2", bus.if_stall, 32'd0);
        adv();
        bus.i_req = 0; eval(); adv();

        // simultaneous fetch and data read: data first
        mem[128] = 32'hD00D_0200; mem[16] = 32'h1111_0040; lat_sel = 1;
        bus.i_req = 1; bus.i_addr = 32'h40; bus.d_req = 1; bus.d_addr = 32'h200; bus.d_we = 4'h0;
        eval();
        chk("t2_d_gnt", bus.d_gnt, 32'd1);
        chk("t2_i_gnt_c0", bus.i_gnt, 32'd0);
        chk("t2_mem_addr_c0", bus.mem_addr, 32'h200);
        adv();
        eval();
        chk("t2_d_rvalid", bus.d_rvalid, 32'd1);
        chk("t2_d_rdata", bus.d_rdata, 32'hD00D_0200);
        chk("t2_i_gnt_c1", bus.i_gnt, 32'd0);
        adv();
        bus.d_req = 0;
        eval();
        chk("t2_i_gnt_c2", bus.i_gnt, 32'd1);
        chk("t2_mem_addr_c2", bus.mem_addr, 32'h40);
        adv();
        eval();
        chk("t2_i_rdata", bus.i_rdata, 32'h1111_0040);
        adv();
        bus.i_req = 0; eval(); adv();

        // three back-to-back word writes
        bus.d_req = 1; bus.d_we = 4'hF;
        for (int k = 0; k < 3; k++) begin
            bus.d_addr = 32'h300 + 32'(4 * k); bus.d_wdata = 32'hA000_0000 + 32'(k);
            eval();
            chk("t3_d_gnt", bus.d_gnt, 32'd1);
            chk("t3_mem_req", bus.mem_req, 32'd1);
            chk("t3_mem_we", bus.mem_we, 32'hF);
            chk("t3_mem_stall", bus.mem_stall, 32'd0);
            chk("t3_d_rvalid", bus.d_rvalid, 32'd0);
            adv();
        end
        bus.d_req = 0; bus.d_we = 4'h0; eval(); adv();

        // starvation bound: continuous data reads with a waiting fetch
        lat_sel = 1; bus.i_req = 1; bus.i_addr = 32'h80; bus.d_req = 1; bus.d_addr = 32'h100;
        first_i = -1; second_i = -1; dg = 0;
        for (int c = 0; c < 16; c++) begin
            eval();
            if (bus.i_gnt) begin
                if (first_i < 0) first_i = c;
                else if (second_i < 0) second_i = c;
            end
            if (bus.d_gnt && first_i < 0) dg++;
            adv();
        end
        chk("t4_d_before_i", 32'(dg), 32'd3);
        chk("t4_first_i_gnt", 32'(first_i), 32'd6);
        chk("t4_second_i_gnt", 32'(second_i), 32'd14);
        bus.i_req = 0; bus.d_req = 0; eval(); adv();

        // reset in the middle of a data read
        lat_sel = 4; bus.d_req = 1; bus.d_addr = 32'h20; bus.d_we = 4'h0;
        eval();
        chk("t5_d_gnt", bus.d_gnt, 32'd1);
        adv();
        reset = 0; bus.i_req = 1; force_rv = 1;
        repeat (2) begin
            eval();
            chk("t5_rst_mem_req", bus.mem_req, 32'd0);
            chk("t5_rst_d_rvalid", bus.d_rvalid, 32'd0);
            chk("t5_rst_mem_stall", bus.mem_stall, 32'd0);
            chk("t5_rst_if_stall", bus.if_stall, 32'd0);
            adv();
        end
        reset = 1; bus.i_req = 0; bus.d_req = 0; force_rv = 0;
        eval(); adv();
        force_rv = 1;
        eval();
        chk("t5_post_d_rvalid", bus.d_rvalid, 32'd0);
        chk("t5_post_mem_req", bus.mem_req, 32'd0);
        adv();
        force_rv = 0;

        // four-cycle fetch stall and the stall counter
        lat_sel = 4; bus.i_req = 1; bus.i_addr = 32'h14;
        repeat (4) begin eval(); adv(); end
        eval();
        chk("t6_i_rvalid", bus.i_rvalid, 32'd1);
`ifdef MEM_ARB_PERF_EN
        chk("t6_perf_i_wait", bus.perf_i_wait, 32'd4);
`else
        chk("t6_perf_i_wait", bus.perf_i_wait, 32'd0);
`endif
        chk("t6_perf_d_wait", bus.perf_d_wait, 32'd0);
        adv();
        bus.i_req = 0; eval(); adv();

        // randomized traffic with spurious responses and dropped requests
        lat_sel = 0; spur_en = 1; i_act = 0; d_act = 0;
        for (int c = 0; c < 2000; c++) begin
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1;
                bus.i_addr = 32'($urandom_range(0, 255)) << 2;
            end else if (i_act && $urandom_range(0, 39) == 0) begin
                i_act = 0;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1;
                bus.d_addr  = 32'($urandom_range(0, 255)) << 2;
                bus.d_wdata = $urandom;
                r = $urandom_range(0, 3);
                bus.d_we = (r < 2) ? 4'h0 : ((r == 2) ? 4'hF : 4'($urandom_range(1, 15)));
            end else if (d_act && $urandom_range(0, 39) == 0) begin
                d_act = 0;
            end
            bus.i_req = i_act;
            bus.d_req = d_act;
            eval();
            if (e_i_rv) i_act = 0;
            if (e_d_rv || (e_d_gnt && bus.d_we != 4'd0)) d_act = 0;
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port and its data (MEM-stage) port.
- Sits between the cpu top-level fetch/data ports and the memory model.
- Serialises accesses, tracks one outstanding read, and returns stall signals that the pipeline uses to freeze IF and MEM.
- Data port has priority; a starvation counter bounds instruction-fetch delay.

Parameters:
- AW, 32, address width of both requesters and memory.
- DW, 32, data width.
- MAX_STARVE, 3, consecutive data grants allowed while a fetch waits before fetch is forced through (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr until i_rvalid.
- i_addr  in  AW  fetch byte address.
- i_gnt  out  1  one-cycle pulse when fetch is issued to memory.
- i_rvalid  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  DW  fetched word.
- d_req  in  1  data request; held with d_addr/d_we/d_wdata until completion.
- d_addr  in  AW  data byte address.
- d_we  in  4  byte write enables; 0 means read.
- d_wdata  in  DW  store data.
- d_gnt  out  1  one-cycle pulse when data access is issued.
- d_rvalid  out  1  one-cycle pulse; d_rdata valid (reads only).
- d_rdata  out  DW  load data.
- if_stall  out  1  freeze IF stage.
- mem_stall  out  1  freeze MEM stage and everything upstream.
- mem_req  out  1  memory command strobe.
- mem_addr  out  AW  memory address.
- mem_we  out  4  memory byte enables.
- mem_wdata  out  DW  memory write data.
- mem_rvalid  in  1  read response strobe; arrives 1..N cycles after the read mem_req.
- mem_rdata  in  DW  read response data.
- perf_i_wait  out  32  fetch stall cycle count (optional feature).
- perf_d_wait  out  32  data stall cycle count (optional feature).

Behaviour:
- FSM states are IDLE, BUSY_I and BUSY_D. Reset forces IDLE.
- All outputs reset to 0 (mem_*, gnt/rvalid, stalls, counters). starve_cnt resets to 0.
- IDLE grant rule, evaluated combinationally in the same cycle:
  - Grant D if d_req && !(i_req && starve_cnt==MAX_STARVE).
  - Else grant I if i_req.
  - Else issue nothing.
- Grant cycle:
  - mem_req=1 for exactly one cycle.
  - mem_addr/mem_we/mem_wdata are driven from the granted requester.
  - The matching gnt pulses in the same cycle.
  - mem_we=0 and mem_wdata=0 on fetch grants.
- Data write (d_we!=0): completes at grant; stay in IDLE; no d_rvalid.
- Reads:
  - A read grant moves the FSM to BUSY_I or BUSY_D.
  - In BUSY_x, mem_rvalid drives x_rvalid=1 and x_rdata=mem_rdata combinationally, then the FSM returns to IDLE.
  - No new grant is issued in the response cycle.
- Rvalid/rdata routing:
  - mem_rvalid in IDLE (spurious or pre-reset) is ignored.
  - i_rdata and d_rdata read 0 when the matching rvalid=0.
- starve_cnt:
  - Increments (saturating at MAX_STARVE) on each D grant while i_req=1.
  - Clears on any I grant.
  - Unchanged otherwise.
- Stalls:
  - if_stall = i_req && !i_rvalid.
  - mem_stall = d_req && !(d_rvalid || (d_gnt && d_we!=0)).
- Requester dropping req while BUSY: the transaction still completes and rvalid still pulses; the requester must discard it.
- Simultaneous fetch and data requests in IDLE: data wins unless starvation is forced.
- Reset mid-read: returns to IDLE; the in-flight response is dropped.
- Throughput:
  - Read occupancy is grant cycle + memory latency, then one IDLE cycle.
  - Writes issue back-to-back, one per cycle.

Optional Feature:
- Macro is MEM_ARB_PERF_EN.
- Defined:
  - perf_i_wait increments every cycle if_stall=1.
  - perf_d_wait increments every cycle mem_stall=1.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared cpu package holds:
  - FSM state encoding: IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2.
  - WE_NONE=4'b0000 and WE_WORD=4'b1111 constants.
  - Default AW/DW.
- One natural sub-module is mem_arb_starve_ctr, the saturating starvation counter plus force-fetch compare.
- All other logic stays flat.

Test Plan:
- Lone fetch, i_addr=0x10, memory latency 2: i_gnt and mem_req at cycle 0; i_rvalid at cycle 2 with mem_rdata; if_stall high in cycles 0-1.
- Simultaneous i_req and d_req read at 0x200: d_gnt first; i_gnt on the cycle after d_rvalid plus one IDLE cycle.
- d_req with d_we=4'b1111 held for 3 writes: three consecutive d_gnt/mem_req cycles, no d_rvalid, mem_stall low on each grant cycle.
- MAX_STARVE=3, d_req reads continuously, i_req held: exactly 3 D grants, then an I grant, and starve_cnt returns to 0.
- Reset asserted in BUSY_D with mem_rvalid arriving 1 cycle after release: FSM is IDLE, d_rvalid stays 0, all outputs are 0 during reset.
- With MEM_ARB_PERF_EN, a 4-cycle fetch stall gives perf_i_wait=4; without the macro it reads 0.
